// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite initiator bridge: response codes,
// protection default and the bridge FSM state encoding.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_e;

endpackage

// File: rtl/axil_watchdog.sv
// Transaction watchdog: down-counter loaded on clear, decremented while
// enabled, single-cycle expiry at terminal count. TIMEOUT=0 disables it.
module axil_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic axi_aclk,
  input  logic axi_aresetn,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned TO_EFF = (TIMEOUT == 0) ? 1 : TIMEOUT;
  localparam int unsigned CW     = (TO_EFF > 1) ? $clog2(TO_EFF) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TO_EFF - 1);
  localparam bit ENABLED = (TIMEOUT != 0);

  logic [CW-1:0] cnt_q;

  // Load on command accept, count down while a transaction is outstanding.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      cnt_q <= LOAD;
    end else if (clr_i) begin
      cnt_q <= LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expired_o = ENABLED && en_i && (cnt_q == '0);

endmodule

// File: rtl/axi4lite_master_bridge.sv
// Single-outstanding AXI4-Lite initiator fed by a command/response port.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready for a command; stray B/R beats are sunk and flagged
// ST_WR_REQ  | AW and W offered, each dropped after its own handshake
// ST_WR_RESP | waiting for the B beat
// ST_RD_REQ  | AR offered until accepted
// ST_RD_DATA | waiting for the R beat
// ST_RSP     | response held on rsp_* until rsp_ready
module axi4lite_master_bridge
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic                busy,
  output logic                stray_err,
  output logic [ADDR_W-1:0]   m_axil_awaddr,
  output logic [2:0]          m_axil_awprot,
  output logic                m_axil_awvalid,
  input  logic                m_axil_awready,
  output logic [DATA_W-1:0]   m_axil_wdata,
  output logic [DATA_W/8-1:0] m_axil_wstrb,
  output logic                m_axil_wvalid,
  input  logic                m_axil_wready,
  input  logic [1:0]          m_axil_bresp,
  input  logic                m_axil_bvalid,
  output logic                m_axil_bready,
  output logic [ADDR_W-1:0]   m_axil_araddr,
  output logic [2:0]          m_axil_arprot,
  output logic                m_axil_arvalid,
  input  logic                m_axil_arready,
  input  logic [DATA_W-1:0]   m_axil_rdata,
  input  logic [1:0]          m_axil_rresp,
  input  logic                m_axil_rvalid,
  output logic                m_axil_rready
);

  state_e              state_q;
  logic                cmd_ready_q, awvalid_q, wvalid_q, arvalid_q;
  logic                bready_q, rready_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                rsp_valid_q, rsp_timeout_q, stray_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [1:0]          rsp_resp_q;

  logic accept, wd_en, wd_expired, completing, timeout_hit;
  logic aw_left, w_left;

  assign accept     = cmd_valid && cmd_ready_q;
  assign wd_en      = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                      (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
  assign completing = ((state_q == ST_WR_RESP) && m_axil_bvalid) ||
                      ((state_q == ST_RD_DATA) && m_axil_rvalid);
  // A B/R completion in the expiry cycle takes precedence over the watchdog.
  assign timeout_hit = wd_expired && !completing;
  assign aw_left     = awvalid_q && !m_axil_awready;
  assign w_left      = wvalid_q && !m_axil_wready;

  axil_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .clr_i       (accept),
    .en_i        (wd_en),
    .expired_o   (wd_expired)
  );

  // Bridge FSM with all handshake and response outputs registered.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_timeout_q <= 1'b0;
      stray_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          bready_q    <= 1'b1;
          rready_q    <= 1'b1;
          if ((m_axil_bvalid && bready_q) || (m_axil_rvalid && rready_q))
            stray_err_q <= 1'b1;
          if (accept) begin
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            wstrb_q     <= cmd_wstrb;
            cmd_ready_q <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          awvalid_q <= aw_left;
          wvalid_q  <= w_left;
          if (!aw_left && !w_left) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (m_axil_bvalid) begin
            rsp_resp_q    <= m_axil_bresp;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            bready_q      <= 1'b0;
            state_q       <= ST_RSP;
          end
        end
        ST_RD_REQ: begin
          if (m_axil_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (m_axil_rvalid) begin
            rsp_resp_q    <= m_axil_rresp;
            rsp_rdata_q   <= m_axil_rdata;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rready_q      <= 1'b0;
            state_q       <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            bready_q    <= 1'b1;
            rready_q    <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Watchdog abort overrides whatever the active state decided.
      if (timeout_hit) begin
        awvalid_q     <= 1'b0;
        wvalid_q      <= 1'b0;
        arvalid_q     <= 1'b0;
        bready_q      <= 1'b0;
        rready_q      <= 1'b0;
        rsp_resp_q    <= RESP_SLVERR;
        rsp_rdata_q   <= '0;
        rsp_timeout_q <= 1'b1;
        rsp_valid_q   <= 1'b1;
        state_q       <= ST_RSP;
      end
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign busy           = (state_q != ST_IDLE);
  assign stray_err      = stray_err_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = PROT_DEFAULT;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = PROT_DEFAULT;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// Directed + randomized bench for axi4lite_master_bridge with a behavioural
// slave and a word-memory reference model.
module tb_axi4lite_master_bridge;
  import axi4lite_pkg::*;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy, stray_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr;
  logic [31:0] m_axil_rdata = '0;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready;
  logic        m_axil_awready = 1'b0, m_axil_wready = 1'b0, m_axil_arready = 1'b0;
  logic        m_axil_bvalid = 1'b0, m_axil_rvalid = 1'b0;
  logic [1:0]  m_axil_bresp = '0, m_axil_rresp = '0;

  axi4lite_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy), .stray_err(stray_err),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  always #5 axi_aclk = ~axi_aclk;

  int cyc = 0;
  always @(posedge axi_aclk) cyc = cyc + 1;

  int total = 0;
  int bad = 0;
  int acc_cyc = 0;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], 16'hC0DE};
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] m = old;
    for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = d[8*i +: 8];
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin @(negedge axi_aclk); n++; end
    chk("cmd_accept", cmd_ready, 1);
    acc_cyc = cyc;
    @(posedge axi_aclk); #1;
    cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_addr = $urandom;
  endtask

  task automatic aw_phase(input logic [31:0] a, input int dly);
    int n = 0;
    while (!m_axil_awvalid && n < 50) begin @(negedge axi_aclk); n++; end
    chk("aw_up", m_axil_awvalid, 1);
    for (int i = 0; i < dly; i++) begin
      @(posedge axi_aclk); #1;
      chk("aw_hold", {m_axil_awvalid, m_axil_awaddr}, {1'b1, a});
    end
    chk("awaddr", {m_axil_awprot, m_axil_awaddr}, {3'b000, a});
    cap_awaddr = m_axil_awaddr;
    m_axil_awready = 1'b1;
    @(posedge axi_aclk); #1 m_axil_awready = 1'b0;
    @(negedge axi_aclk);
    chk("aw_drop", m_axil_awvalid, 0);
  endtask

  task automatic w_phase(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n = 0;
    while (!m_axil_wvalid && n < 50) begin @(negedge axi_aclk); n++; end
    chk("w_up", m_axil_wvalid, 1);
    for (int i = 0; i < dly; i++) begin
      @(posedge axi_aclk); #1;
      chk("w_hold", {m_axil_wvalid, m_axil_wstrb, m_axil_wdata}, {1'b1, s, d});
    end
    chk("wdata", {m_axil_wstrb, m_axil_wdata}, {s, d});
    cap_wdata = m_axil_wdata; cap_wstrb = m_axil_wstrb;
    m_axil_wready = 1'b1;
    @(posedge axi_aclk); #1 m_axil_wready = 1'b0;
    @(negedge axi_aclk);
    chk("w_drop", m_axil_wvalid, 0);
  endtask

  task automatic ar_phase(input logic [31:0] a, input int dly);
    int n = 0;
    while (!m_axil_arvalid && n < 50) begin @(negedge axi_aclk); n++; end
    chk("ar_up", m_axil_arvalid, 1);
    for (int i = 0; i < dly; i++) begin
      @(posedge axi_aclk); #1;
      chk("ar_hold", {m_axil_arvalid, m_axil_araddr}, {1'b1, a});
    end
    chk("araddr", {m_axil_arprot, m_axil_araddr}, {3'b000, a});
    cap_araddr = m_axil_araddr;
    m_axil_arready = 1'b1;
    @(posedge axi_aclk); #1 m_axil_arready = 1'b0;
    @(negedge axi_aclk);
    chk("ar_drop", m_axil_arvalid, 0);
  endtask

  task automatic b_phase(input int dly, input logic [1:0] resp);
    int n = 0;
    repeat (dly) @(negedge axi_aclk);
    m_axil_bvalid = 1'b1; m_axil_bresp = resp;
    while (!m_axil_bready && n < 50) begin @(negedge axi_aclk); n++; end
    chk("b_hs", m_axil_bready, 1);
    @(posedge axi_aclk); #1 m_axil_bvalid = 1'b0; m_axil_bresp = ~resp;
  endtask

  task automatic r_phase(input int dly, input logic [1:0] resp);
    int n = 0;
    repeat (dly) @(negedge axi_aclk);
    m_axil_rvalid = 1'b1; m_axil_rresp = resp; m_axil_rdata = slv_rd(cap_araddr);
    while (!m_axil_rready && n < 50) begin @(negedge axi_aclk); n++; end
    chk("r_hs", m_axil_rready, 1);
    @(posedge axi_aclk); #1 m_axil_rvalid = 1'b0; m_axil_rresp = ~resp; m_axil_rdata = $urandom;
  endtask

  task automatic get_rsp(input string tag, input logic [1:0] eresp, input logic [31:0] edata,
                         input logic eto, input int elat);
    int n = 0;
    while (!rsp_valid && n < 100) begin @(negedge axi_aclk); n++; end
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_lat"}, cyc - acc_cyc, elat);
    chk({tag, "_rsp"}, {rsp_timeout, rsp_resp, rsp_rdata}, {eto, eresp, edata});
    chk({tag, "_cmdrdy"}, cmd_ready, 0);
    rsp_ready = 1'b1;
    @(posedge axi_aclk); #1 rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, rsp_valid, 0);
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int awd, input int wd, input int bd,
                          input logic [1:0] resp);
    issue(1'b1, a, d, s);
    fork
      aw_phase(a, awd);
      w_phase(d, s, wd);
    join
    slv_mem[cap_awaddr] = merge(slv_rd(cap_awaddr), cap_wdata, cap_wstrb);
    ref_mem[a] = merge(ref_rd(a), d, s);
    b_phase(bd, resp);
    get_rsp(tag, resp, 32'h0, 1'b0, 3 + ((awd > wd) ? awd : wd) + bd);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input int ard, input int rd,
                         input logic [1:0] resp);
    logic [31:0] exp_d;
    exp_d = ref_rd(a);
    issue(1'b0, a, 32'h0, 4'h0);
    ar_phase(a, ard);
    r_phase(rd, resp);
    get_rsp(tag, resp, exp_d, 1'b0, 3 + ard + rd);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: observed=expired expected=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int hs;
    logic        wr;
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [1:0]  r;

    // Reset values.
    #2;
    chk("rst_ctl", {cmd_ready, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, rsp_valid,
                    rsp_timeout, stray_err, busy}, 8'h00);
    chk("rst_payload", {m_axil_awaddr, m_axil_wdata, m_axil_wstrb, m_axil_araddr}, 100'h0);
    chk("rst_prot", {m_axil_awprot, m_axil_arprot}, 6'h0);
    @(negedge axi_aclk); axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    chk("post_rst", {cmd_ready, m_axil_bready, m_axil_rready, busy}, 4'b1110);

    // Zero-wait write, then read it back.
    do_write("wr0", 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, RESP_OKAY);
    do_read("rdback", 32'h0000_1004, 0, 0, RESP_OKAY);

    // Read with 2 AR wait cycles and 3 R wait cycles.
    slv_mem[32'h10] = 32'h1234_5678;
    ref_mem[32'h10] = 32'h1234_5678;
    do_read("rd_wait", 32'h0000_0010, 2, 3, RESP_OKAY);

    // W before AW, then AW before W; plus response code passthrough.
    do_write("w_first", 32'h0000_0020, 32'hA1B2_C3D4, 4'h5, 4, 0, 0, RESP_SLVERR);
    do_write("aw_first", 32'h0000_0024, 32'h0F0F_F0F0, 4'hA, 0, 4, 1, RESP_DECERR);
    do_read("rd_w_first", 32'h0000_0020, 0, 1, RESP_EXOKAY);

    // B arrives in the very cycle the watchdog expires: completion wins.
    do_write("b_at_expiry", 32'h0000_0030, 32'h5555_AAAA, 4'hF, 0, 0, 14, RESP_EXOKAY);

    // AR never accepted: valid held through cycle 16, dropped with timeout.
    issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    @(negedge axi_aclk);
    repeat (15) @(negedge axi_aclk);
    chk("ar_to_held", m_axil_arvalid, 1);
    @(negedge axi_aclk);
    chk("ar_to_drop", {m_axil_arvalid, rsp_valid}, 2'b01);
    get_rsp("rd_to", RESP_SLVERR, 32'h0, 1'b1, 17);

    // B never arrives: timeout response, later stray B is sunk and flagged.
    issue(1'b1, 32'h0000_0050, 32'hCAFE_F00D, 4'hF);
    fork
      aw_phase(32'h0000_0050, 0);
      w_phase(32'hCAFE_F00D, 4'hF, 0);
    join
    get_rsp("wr_to", RESP_SLVERR, 32'h0, 1'b1, 17);
    chk("valids_after_to", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 3'b000);
    chk("stray_before", stray_err, 0);
    m_axil_bvalid = 1'b1; m_axil_bresp = RESP_OKAY;
    @(posedge axi_aclk); #1 m_axil_bvalid = 1'b0;
    @(negedge axi_aclk);
    chk("stray_after", {stray_err, busy}, 2'b10);

    // Response back-pressure with a competing command held on cmd_valid.
    issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    ar_phase(32'h0000_0010, 0);
    r_phase(0, RESP_DECERR);
    begin
      int n = 0;
      while (!rsp_valid && n < 50) begin @(negedge axi_aclk); n++; end
    end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge axi_aclk);
      chk("hold_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata},
          {1'b1, 1'b0, RESP_DECERR, 32'h1234_5678});
      chk("hold_ctl", {cmd_ready, busy}, 2'b01);
    end
    rsp_ready = 1'b1; hs = cyc;
    @(posedge axi_aclk); #1 rsp_ready = 1'b0; cmd_valid = 1'b0;
    do_read("after_hold", 32'h0000_1004, 0, 0, RESP_OKAY);
    chk("accept_next_cycle", acc_cyc - hs, 1);

    // Asynchronous reset while in WR_REQ.
    issue(1'b1, 32'h0000_0060, 32'h7777_8888, 4'hF);
    @(negedge axi_aclk);
    chk("wr_req_busy", {busy, m_axil_awvalid, m_axil_wvalid}, 3'b111);
    #2 axi_aresetn = 1'b0;
    #1 chk("async_rst", {m_axil_awvalid, m_axil_wvalid, rsp_valid, busy, stray_err}, 5'b0);
    @(negedge axi_aclk); axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    chk("rst_no_rsp", rsp_valid, 0);
    do_read("rd_after_rst", 32'h0000_0024, 1, 0, RESP_OKAY);

    // Randomized traffic over a small address window.
    for (int k = 0; k < 24; k++) begin
      wr = 1'($urandom_range(0, 1));
      a  = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
      d  = $urandom;
      s  = 4'($urandom_range(1, 15));
      r  = 2'($urandom_range(0, 3));
      if (wr)
        do_write("rnd_wr", a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), r);
      else
        do_read("rnd_rd", a, $urandom_range(0, 3), $urandom_range(0, 3), r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
